// File: rtl/mole_lifecycle.sv
// Mole lifecycle controller: accepts a hole index, raises that mole for a fixed number
// of ticks, scores a whack or a miss, then waits a gap before asking for the next hole.
module mole_lifecycle #(
    parameter int unsigned NUM_HOLES = 8,
    parameter int unsigned UP_TICKS  = 8,
    parameter int unsigned GAP_TICKS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 game_en,
    input  logic                 clr,
    input  logic [2:0]           pos,
    input  logic                 pos_valid,
    output logic                 pos_ready,
    input  logic [NUM_HOLES-1:0] hit_btn,
    output logic [NUM_HOLES-1:0] mole,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic [7:0]           score,
    output logic [7:0]           misses
);

    // A zero tick count behaves as one tick.
    localparam logic [7:0] UpLoad  = (UP_TICKS == 0) ? 8'd1 : 8'(UP_TICKS);
    localparam logic [7:0] GapLoad = (GAP_TICKS == 0) ? 8'd1 : 8'(GAP_TICKS);
    localparam logic [NUM_HOLES-1:0] OneHole = NUM_HOLES'(1);

    typedef enum logic [1:0] {StIdle, StWaitPos, StUp, StGap} state_e;

    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [NUM_HOLES-1:0]  mole_q, mole_d;
    logic                  hit_pulse_q, hit_pulse_d;
    logic                  miss_pulse_q, miss_pulse_d;
    logic [7:0]            score_q, score_d;
    logic [7:0]            misses_q, misses_d;

    logic xfer;
    logic pos_ok;
    logic hit;

    assign pos_ready = game_en && (state_q == StWaitPos);
    assign xfer      = pos_valid && pos_ready;
    assign pos_ok    = ({29'd0, pos} < NUM_HOLES);
    // mole_q is the one-hot of the latched hole while up, so only that button counts.
    assign hit       = |(hit_btn & mole_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mole_d       = mole_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
        score_d      = score_q;
        misses_d     = misses_q;

        if (!game_en) begin
            state_d = StIdle;
            mole_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StWaitPos;
                StWaitPos: begin
                    if (xfer && pos_ok) begin
                        mole_d  = OneHole << pos;
                        cnt_d   = UpLoad;
                        state_d = StUp;
                    end
                end
                StUp: begin
                    // A whack wins over expiry in the same clock.
                    if (hit) begin
                        hit_pulse_d = 1'b1;
                        if (score_q != 8'hFF) score_d = score_q + 8'd1;
                        mole_d  = '0;
                        cnt_d   = GapLoad;
                        state_d = StGap;
                    end else if (tick) begin
                        if (cnt_q <= 8'd1) begin
                            miss_pulse_d = 1'b1;
                            if (misses_q != 8'hFF) misses_d = misses_q + 8'd1;
                            mole_d  = '0;
                            cnt_d   = GapLoad;
                            state_d = StGap;
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end
                end
                StGap: begin
                    if (tick) begin
                        if (cnt_q <= 8'd1) state_d = StWaitPos;
                        else               cnt_d   = cnt_q - 8'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (clr) begin
            score_d  = 8'd0;
            misses_d = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 8'd0;
            mole_q       <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            score_q      <= 8'd0;
            misses_q     <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mole_q       <= mole_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
        end
    end

    assign mole       = mole_q;
    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;
    assign score      = score_q;
    assign misses     = misses_q;

endmodule

// File: tb/tb_mole_lifecycle.sv
// Directed bench for mole_lifecycle: an 8-hole default instance and a 6-hole instance
// with zero tick counts share stimulus.
module tb_mole_lifecycle;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       game_en = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] pos = 3'd0;
    logic       pos_valid = 1'b0;
    logic [7:0] hit_btn = 8'd0;

    logic       ready8, hit8, miss8;
    logic [7:0] mole8, score8, misses8;
    logic       ready6, hit6, miss6;
    logic [5:0] mole6;
    logic [7:0] score6, misses6;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mole_lifecycle dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .game_en    (game_en),
        .clr        (clr),
        .pos        (pos),
        .pos_valid  (pos_valid),
        .pos_ready  (ready8),
        .hit_btn    (hit_btn),
        .mole       (mole8),
        .hit_pulse  (hit8),
        .miss_pulse (miss8),
        .score      (score8),
        .misses     (misses8)
    );

    mole_lifecycle #(
        .NUM_HOLES (6),
        .UP_TICKS  (0),
        .GAP_TICKS (0)
    ) dut6 (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .game_en    (game_en),
        .clr        (clr),
        .pos        (pos),
        .pos_valid  (pos_valid),
        .pos_ready  (ready6),
        .hit_btn    (hit_btn[5:0]),
        .mole       (mole6),
        .hit_pulse  (hit6),
        .miss_pulse (miss6),
        .score      (score6),
        .misses     (misses6)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick1();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic xfer(input logic [2:0] p);
        pos       = p;
        pos_valid = 1'b1;
        cyc();
        pos_valid = 1'b0;
    endtask

    initial begin
        // Reset state, asserted before any clock edge
        #1 rst = 1'b1;
        #2;
        chk("rst_mole", 32'(mole8), 32'h0);
        chk("rst_ready", 32'(ready8), 32'h0);
        chk("rst_hit", 32'(hit8), 32'h0);
        chk("rst_miss", 32'(miss8), 32'h0);
        chk("rst_score", 32'(score8), 32'h0);
        chk("rst_misses", 32'(misses8), 32'h0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("idle_ready", 32'(ready8), 32'h0);
        game_en = 1'b1;
        cyc();
        chk("wait_ready", 32'(ready8), 32'h1);

        // Basic hit on hole 3 at the second tick
        xfer(3'd3);
        chk("hit_mole_up", 32'(mole8), 32'h08);
        chk("hit_ready_up", 32'(ready8), 32'h0);
        tick1();
        chk("hit_mole_tick1", 32'(mole8), 32'h08);
        tick = 1'b1;
        hit_btn = 8'h08;
        cyc();
        tick = 1'b0;
        hit_btn = 8'h00;
        chk("hit_pulse", 32'(hit8), 32'h1);
        chk("hit_no_miss", 32'(miss8), 32'h0);
        chk("hit_score", 32'(score8), 32'h1);
        chk("hit_mole_clr", 32'(mole8), 32'h0);
        cyc();
        chk("hit_pulse_1clk", 32'(hit8), 32'h0);
        tick1();
        chk("gap_mole", 32'(mole8), 32'h0);
        chk("gap_ready", 32'(ready8), 32'h0);
        tick1();
        chk("gap_done_ready", 32'(ready8), 32'h1);

        // Expiry on hole 5 after exactly 8 ticks
        xfer(3'd5);
        for (int i = 0; i < 7; i++) tick1();
        chk("exp_mole_t7", 32'(mole8), 32'h20);
        chk("exp_no_miss_t7", 32'(miss8), 32'h0);
        tick1();
        chk("exp_miss", 32'(miss8), 32'h1);
        chk("exp_mole_clr", 32'(mole8), 32'h0);
        chk("exp_misses", 32'(misses8), 32'h1);
        chk("exp_score", 32'(score8), 32'h1);
        cyc();
        chk("exp_miss_1clk", 32'(miss8), 32'h0);
        tick1();
        tick1();
        chk("exp_gap_ready", 32'(ready8), 32'h1);

        // Wrong button, then the right button on the final tick
        xfer(3'd1);
        hit_btn = 8'h04;
        cyc();
        hit_btn = 8'h00;
        chk("wrong_mole", 32'(mole8), 32'h02);
        chk("wrong_hit", 32'(hit8), 32'h0);
        for (int i = 0; i < 7; i++) tick1();
        tick = 1'b1;
        hit_btn = 8'h02;
        cyc();
        tick = 1'b0;
        hit_btn = 8'h00;
        chk("sim_hit", 32'(hit8), 32'h1);
        chk("sim_no_miss", 32'(miss8), 32'h0);
        chk("sim_misses", 32'(misses8), 32'h1);
        chk("sim_score", 32'(score8), 32'h2);
        tick1();
        tick1();

        // Disable mid-UP, then asynchronous reset mid-UP
        xfer(3'd4);
        chk("dis_mole_up", 32'(mole8), 32'h10);
        game_en = 1'b0;
        cyc();
        chk("dis_mole", 32'(mole8), 32'h0);
        chk("dis_ready", 32'(ready8), 32'h0);
        chk("dis_score", 32'(score8), 32'h2);
        game_en = 1'b1;
        cyc();
        chk("dis_resume_ready", 32'(ready8), 32'h1);
        xfer(3'd6);
        chk("rst_up_mole", 32'(mole8), 32'h40);
        #2 rst = 1'b1;
        #1;
        chk("arst_mole", 32'(mole8), 32'h0);
        chk("arst_score", 32'(score8), 32'h0);
        chk("arst_misses", 32'(misses8), 32'h0);
        chk("arst_hit", 32'(hit8), 32'h0);
        chk("arst_miss", 32'(miss8), 32'h0);
        chk("arst_ready", 32'(ready8), 32'h0);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_hit", 32'(hit8), 32'h0);
        chk("post_rst_miss", 32'(miss8), 32'h0);
        chk("post_rst_ready", 32'(ready8), 32'h1);

        // Invalid position on the 6-hole instance; pos 7 is valid with 8 holes
        xfer(3'd7);
        chk("inv_mole6", 32'(mole6), 32'h0);
        chk("inv_ready6", 32'(ready6), 32'h1);
        chk("inv_mole8", 32'(mole8), 32'h80);
        game_en = 1'b0;
        cyc();
        game_en = 1'b1;
        cyc();

        // Zero tick counts clamp to one tick
        xfer(3'd2);
        chk("clamp_mole6", 32'(mole6), 32'h04);
        tick1();
        chk("clamp_miss6", 32'(miss6), 32'h1);
        chk("clamp_mole6_clr", 32'(mole6), 32'h0);
        chk("clamp_miss8", 32'(miss8), 32'h0);
        chk("clamp_mole8", 32'(mole8), 32'h04);
        tick1();
        chk("clamp_gap6_ready", 32'(ready6), 32'h1);
        game_en = 1'b0;
        cyc();
        game_en = 1'b1;
        cyc();

        // 256 hits saturate the score at 255
        for (int i = 0; i < 256; i++) begin
            xfer(3'd0);
            hit_btn = 8'h01;
            cyc();
            hit_btn = 8'h00;
            tick1();
            tick1();
        end
        chk("sat_score8", 32'(score8), 32'hFF);
        chk("sat_score6", 32'(score6), 32'hFF);
        chk("sat_ready8", 32'(ready8), 32'h1);

        // Clear wins over a same-cycle hit
        xfer(3'd0);
        hit_btn = 8'h01;
        clr = 1'b1;
        cyc();
        hit_btn = 8'h00;
        clr = 1'b0;
        chk("clr_hit8", 32'(hit8), 32'h1);
        chk("clr_score8", 32'(score8), 32'h0);
        chk("clr_misses6", 32'(misses6), 32'h0);
        chk("clr_mole8", 32'(mole8), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
